// File: rtl/anton_neopixel_stream_unit_pkg.sv
// Shared definitions for the NeoPixel stream unit: buffer sizing macros,
// latch-state encodings and the fixed bit-slot waveform timing.
`ifndef ANTON_NEOPIXEL_STREAM_UNIT_DEFS
`define ANTON_NEOPIXEL_STREAM_UNIT_DEFS
`define CLOG2(x) $clog2(x)
`define BUFFER_END_DEFAULT 255
`endif

package anton_neopixel_stream_unit_pkg;

    typedef enum logic {
        ENUM_STATE_TRANSMIT = 1'b0,
        ENUM_STATE_RESET    = 1'b1
    } stream_state_e;

    // One bit slot is 8 ticks of the 7 MHz clock (~1.14 us).
    localparam logic [2:0] PATTERN_LAST   = 3'd7;
    // Last high tick of the slot: 0-4 for a one (~714 ns), 0-1 for a zero (~286 ns).
    localparam logic [2:0] ONE_HIGH_LAST  = 3'd4;
    localparam logic [2:0] ZERO_HIGH_LAST = 3'd1;

    localparam logic [4:0] BIT_LAST_32 = 5'd23;
    localparam logic [4:0] BIT_LAST_8  = 5'd7;

endpackage

// File: rtl/anton_neopixel_bit_timer.sv
// Bit-slot tick counter for the NeoPixel stream: counts 0-7 while streaming
// and raises the end-of-slot and end-of-pixel pulses.
module anton_neopixel_bit_timer
    import anton_neopixel_stream_unit_pkg::*;
(
    input  logic       clk7mhz,
    input  logic       rst,
    input  logic       reg_ctrl_init,
    input  logic       reg_ctrl_run,
    input  logic       reg_ctrl_32bit,
    input  logic       state,
    input  logic [4:0] pixel_bit_index,
    output logic [2:0] bit_pattern_index,
    output logic       stream_output,
    output logic       stream_reset,
    output logic       stream_pattern_of,
    output logic       stream_bit_of
);

    logic [2:0] count_reg;
    logic [2:0] count_next;
    logic [4:0] bit_last;

    assign stream_output = reg_ctrl_run && (state == ENUM_STATE_TRANSMIT);
    assign stream_reset  = reg_ctrl_run && (state == ENUM_STATE_RESET);

    // Leaving the transmit state mid-slot drops the counter back to 0, aborting the slot.
    always_comb begin
        count_next = 3'd0;
        if (!reg_ctrl_init && stream_output) begin
            count_next = count_reg + 3'd1;
        end
    end

    always_ff @(posedge clk7mhz or posedge rst) begin
        if (rst) begin
            count_reg <= 3'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign bit_last          = reg_ctrl_32bit ? BIT_LAST_32 : BIT_LAST_8;
    assign bit_pattern_index = count_reg;
    assign stream_pattern_of = stream_output && (count_reg == PATTERN_LAST);
    assign stream_bit_of     = stream_pattern_of && (pixel_bit_index == bit_last);

endmodule

// File: rtl/anton_neopixel_stream_unit.sv
// NeoPixel serialiser: picks the current bit out of the pixel buffer and
// shapes it into the 8-tick high/low waveform on neoData.
module anton_neopixel_stream_unit
    import anton_neopixel_stream_unit_pkg::*;
#(
    parameter int BUFFER_END  = `BUFFER_END_DEFAULT,
    localparam int BUFFER_BITS = `CLOG2(BUFFER_END + 1)
) (
    input  logic                   clk7mhz,
    input  logic                   rst,
    input  logic                   reg_ctrl_init,
    input  logic                   reg_ctrl_run,
    input  logic                   reg_ctrl_32bit,
    input  logic                   state,
    input  logic [BUFFER_BITS-1:0] pixel_index,
    input  logic [4:0]             pixel_bit_index,
    output logic [BUFFER_BITS-1:0] buf_addr,
    input  logic [7:0]             buf_data,
    output logic                   neoData,
    output logic [2:0]             bit_pattern_index_out,
    output logic                   stream_output,
    output logic                   stream_reset,
    output logic                   stream_pattern_of,
    output logic                   stream_bit_of
);

    logic [BUFFER_BITS-1:0] byte_offset;
    logic                   bit_value;
    logic [2:0]             high_last;

    anton_neopixel_bit_timer u_bit_timer (
        .clk7mhz           (clk7mhz),
        .rst               (rst),
        .reg_ctrl_init     (reg_ctrl_init),
        .reg_ctrl_run      (reg_ctrl_run),
        .reg_ctrl_32bit    (reg_ctrl_32bit),
        .state             (state),
        .pixel_bit_index   (pixel_bit_index),
        .bit_pattern_index (bit_pattern_index_out),
        .stream_output     (stream_output),
        .stream_reset      (stream_reset),
        .stream_pattern_of (stream_pattern_of),
        .stream_bit_of     (stream_bit_of)
    );

    // In 32-bit mode bits 4:3 of the bit index select byte 0..2 of the slot;
    // the sum wraps at the buffer address width.
    assign byte_offset = reg_ctrl_32bit ? BUFFER_BITS'(pixel_bit_index[4:3]) : '0;
    assign buf_addr    = pixel_index + byte_offset;

    // Bytes go out MSB first.
    assign bit_value = buf_data[3'd7 - pixel_bit_index[2:0]];
    assign high_last = bit_value ? ONE_HIGH_LAST : ZERO_HIGH_LAST;
    assign neoData   = stream_output && (bit_pattern_index_out <= high_last);

endmodule

// File: tb/tb_anton_neopixel_stream_unit.sv
// Scoreboard bench for the NeoPixel stream unit: a tick-level model pushes
// expected outputs per tick, the monitor pops and compares them.
module tb_anton_neopixel_stream_unit;

    typedef struct packed {
        logic       neo;
        logic       so;
        logic       sr;
        logic       pof;
        logic       bof;
        logic [2:0] cnt;
        logic [7:0] addr;
    } exp_t;

    logic       clk7mhz = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic       run = 1'b0;
    logic       m32 = 1'b0;
    logic       st = 1'b0;
    logic [7:0] pidx = 8'd0;
    logic [4:0] pbi = 5'd0;
    logic [7:0] buf_addr;
    logic [7:0] buf_data;
    logic       neo_data;
    logic [2:0] pat_idx;
    logic       s_out, s_rst, s_pof, s_bof;

    logic [7:0] mem [0:255];
    exp_t       exp_q [$];
    logic [2:0] mdl_cnt = 3'd0;
    int         checks = 0;
    int         failures = 0;
    int         neo_hi = 0;
    int         bof_seen = 0;
    int         pof_seen = 0;

    assign buf_data = mem[buf_addr];

    always #5 clk7mhz = ~clk7mhz;

    anton_neopixel_stream_unit dut (
        .clk7mhz               (clk7mhz),
        .rst                   (rst),
        .reg_ctrl_init         (init),
        .reg_ctrl_run          (run),
        .reg_ctrl_32bit        (m32),
        .state                 (st),
        .pixel_index           (pidx),
        .pixel_bit_index       (pbi),
        .buf_addr              (buf_addr),
        .buf_data              (buf_data),
        .neoData               (neo_data),
        .bit_pattern_index_out (pat_idx),
        .stream_output         (s_out),
        .stream_reset          (s_rst),
        .stream_pattern_of     (s_pof),
        .stream_bit_of         (s_bof)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        logic [7:0] byte_v;
        int bit_idx;
        logic bit_v;
        e.so   = run && !st;
        e.sr   = run && st;
        e.cnt  = mdl_cnt;
        e.pof  = e.so && (mdl_cnt == 3'd7);
        e.bof  = e.pof && (int'(pbi) == (m32 ? 23 : 7));
        e.addr = m32 ? 8'(int'(pidx) + int'(pbi) / 8) : pidx;
        byte_v = mem[e.addr];
        bit_idx = 7 - (int'(pbi) % 8);
        bit_v  = byte_v[bit_idx];
        e.neo  = e.so && (int'(mdl_cnt) < (bit_v ? 5 : 2));
        exp_q.push_back(e);
    endtask

    task automatic collect();
        exp_t e;
        e = exp_q.pop_front();
        $display("t=%0t run=%0b st=%0b m32=%0b pidx=%0d pbi=%0d cnt=%0d addr=%0d neo=%0b pof=%0b bof=%0b",
                 $time, run, st, m32, pidx, pbi, pat_idx, buf_addr, neo_data, s_pof, s_bof);
        check_val("neoData", 32'(neo_data), 32'(e.neo));
        check_val("stream_output", 32'(s_out), 32'(e.so));
        check_val("stream_reset", 32'(s_rst), 32'(e.sr));
        check_val("pattern_of", 32'(s_pof), 32'(e.pof));
        check_val("bit_of", 32'(s_bof), 32'(e.bof));
        check_val("counter", 32'(pat_idx), 32'(e.cnt));
        check_val("buf_addr", 32'(buf_addr), 32'(e.addr));
        if (neo_data) neo_hi++;
        if (s_bof) bof_seen++;
        if (s_pof) pof_seen++;
    endtask

    // Inputs are applied at the falling edge; outputs sampled 1 time unit later.
    task automatic tick();
        #1;
        if (rst) mdl_cnt = 3'd0;
        push_expected();
        collect();
        @(posedge clk7mhz);
        if (rst || init || !(run && !st)) mdl_cnt = 3'd0;
        else mdl_cnt = mdl_cnt + 3'd1;
        @(negedge clk7mhz);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        @(negedge clk7mhz);

        // Reset state
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // 8-bit mode, one bit then zero bit
        mem[10] = 8'h80;
        pidx = 8'd10; run = 1'b1;
        neo_hi = 0;
        repeat (8) tick();
        check_val("one_high_ticks", 32'(neo_hi), 32'd5);
        pbi = 5'd1; neo_hi = 0;
        repeat (8) tick();
        check_val("zero_high_ticks", 32'(neo_hi), 32'd2);

        // 32-bit mode pixel at address 4
        m32 = 1'b1; pidx = 8'd4; bof_seen = 0;
        for (int b = 0; b < 24; b++) begin
            pbi = 5'(b);
            repeat (8) tick();
        end
        check_val("bof_per_pixel32", 32'(bof_seen), 32'd1);

        // 8-bit mode, two bytes
        m32 = 1'b0; pidx = 8'd77; bof_seen = 0; pof_seen = 0;
        for (int b = 0; b < 16; b++) begin
            if (b == 8) pidx = 8'd78;
            pbi = 5'(b % 8);
            repeat (8) tick();
        end
        check_val("bof_per_byte8", 32'(bof_seen), 32'd2);
        check_val("pof_count", 32'(pof_seen), 32'd16);

        // Address wrap at buffer end
        m32 = 1'b1; pidx = 8'd255; pbi = 5'd16;
        repeat (8) tick();
        pbi = 5'd8;
        repeat (8) tick();

        // Reset period and run low
        m32 = 1'b0; pidx = 8'd10; pbi = 5'd0;
        repeat (3) tick();
        st = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        repeat (2) tick();

        // Async reset mid-slot at counter 4
        st = 1'b0; run = 1'b1;
        for (int n = 0; n < 16 && mdl_cnt != 3'd4; n++) tick();
        check_val("reached_cnt4", 32'(pat_idx), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // Soft init mid-slot
        init = 1'b1;
        tick();
        init = 1'b0;
        repeat (3) tick();

        // Abort by dropping run mid-slot
        run = 1'b0;
        tick();
        run = 1'b1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
